// File: rtl/operand_stack.sv
// LIFO operand stack for the stack CPU: DEPTH registers of WIDTH bits with
// zero-latency TOS/NOS read through 8:1 slot muxes indexed by the occupancy count.
module operand_stack #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] slot [8];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_m1;
  logic [CW-1:0]    cnt_m2;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;
  logic [2:0]       tos_sel;
  logic [2:0]       nos_sel;

  assign cnt_m1  = cnt - CW'(1);
  assign cnt_m2  = cnt - CW'(2);
  assign wr_idx  = IW'(cnt);
  assign top_idx = IW'(cnt_m1);

  // Storage and occupancy: rejected ops leave every entry untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      unique case ({push, pop})
        2'b10: begin
          if (cnt < CNT_MAX) begin
            mem[wr_idx] <= din;
            cnt         <= cnt + CW'(1);
          end else begin
            overflow <= 1'b1;
          end
        end
        2'b01: begin
          if (cnt != '0) cnt <= cnt_m1;
          else           underflow <= 1'b1;
        end
        2'b11: begin
          // Replace is the ALU write-back path; from empty it degrades to a push.
          if (cnt != '0) begin
            mem[top_idx] <= din;
          end else begin
            mem[0] <= din;
            cnt    <= CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Read side: fixed 8-input slot array, unused slots tied to zero.
  for (genvar g = 0; g < 8; g++) begin : g_slot
    if (g < DEPTH) begin : g_used
      assign slot[g] = mem[g];
    end else begin : g_tied
      assign slot[g] = '0;
    end
  end

  assign tos_sel = 3'(cnt_m1);
  assign nos_sel = 3'(cnt_m2);

  assign tos   = (cnt != '0)       ? slot[tos_sel] : '0;
  assign nos   = (cnt >= CW'(2))   ? slot[nos_sel] : '0;
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_MAX);

endmodule
